// File: rtl/imem_loader.sv
// imem_loader
//   Write-side loader for the instruction memory. Takes a little-endian byte
//   stream: a 32-bit word count N, then N instruction words. It assembles each
//   word, drives the imem write port, and holds the CPU in reset until the
//   whole image has been written.
//
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//     When defined, a 4-byte LE trailer follows the last word. The trailer must
//     equal the sum of all data words mod 2**32, otherwise the load ends in ERROR.
//
// Ports
//   clk           system clock, all state on posedge
//   rst_n         asynchronous active-low reset
//   start_i       begin a load (sampled only in IDLE/DONE/ERROR)
//   byte_valid_i  byte_data_i is valid
//   byte_data_i   stream byte, LSB-first within each word
//   byte_ready_o  loader accepts a byte this cycle
//   imem_we_o     one-cycle write strobe
//   imem_addr_o   byte address = BASE_ADDR + 4*index
//   imem_wdata_o  assembled word
//   cpu_hold_o    active-high reset request to the CPU core
//   busy_o        load in progress
//   done_o        image loaded OK (level, cleared by next start)
//   error_o       bad length or checksum (level, cleared by next start)
//
// state  | meaning
// IDLE   | waiting for first start since reset
// LEN    | collecting the 4-byte word count N
// DATA   | collecting the 4 bytes of the current word
// WRITE  | one-cycle imem write of the assembled word
// DONE   | image loaded, CPU released
// ERROR  | length (or checksum) rejected, CPU held
// CSUM   | collecting the 4-byte checksum trailer (checksum build only)
module imem_loader #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter logic [31:0] BASE_ADDR     = 32'h0,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM = 3'd6
`endif
  } state_t;

  localparam logic [31:0]         DEPTH   = 32'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [31:0]           n_q, n_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  hold_q, hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]           csum_q, csum_d;
`endif

  logic [31:0]           n_shift;
  logic [31:0]           w_shift;
  logic [ADDR_WIDTH:0]   idx_inc;
  logic                  last_byte;
  logic                  finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= HOLD_AT_RESET;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      n_q     <= n_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      done_q  <= done_d;
      error_q <= error_d;
      hold_q  <= hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    wdata_d      = wdata_q;
    idx_d        = idx_q;
    bcnt_d       = bcnt_q;
    done_d       = done_q;
    error_d      = error_q;
    hold_d       = hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    byte_ready_o = 1'b0;
    imem_we_o    = 1'b0;
    busy_o       = 1'b0;
    finish       = 1'b0;

    // Bytes arrive LSB-first, so shifting in from the top leaves byte k at
    // bits [8k+7:8k] after the fourth byte.
    n_shift   = {byte_data_i, n_q[31:8]};
    w_shift   = {byte_data_i, wdata_q[31:8]};
    idx_inc   = idx_q + IDX_ONE;
    last_byte = (bcnt_q == 2'd3);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_LEN;
          idx_d   = '0;
          bcnt_d  = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          hold_d  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) begin
          n_d    = n_shift;
          bcnt_d = bcnt_q + 2'd1;
          if (last_byte) begin
            if (n_shift > DEPTH) begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end else if (n_shift == '0) begin
              finish = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) begin
          wdata_d = w_shift;
          bcnt_d  = bcnt_q + 2'd1;
          if (last_byte) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        busy_o    = 1'b1;
        imem_we_o = 1'b1;
        idx_d     = idx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q + wdata_q;
`endif
        // N never exceeds 2**ADDR_WIDTH here, so its low ADDR_WIDTH+1 bits
        // hold the full count.
        if (idx_inc == n_q[ADDR_WIDTH:0]) begin
          finish = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (byte_valid_i) begin
          // N is no longer needed, so its register collects the trailer.
          n_d    = n_shift;
          bcnt_d = bcnt_q + 2'd1;
          if (last_byte) begin
            if (n_shift == csum_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
            end else begin
              state_d = S_ERROR;
              error_d = 1'b1;
            end
          end
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      state_d = S_CSUM;
`else
      state_d = S_DONE;
      done_d  = 1'b1;
      hold_d  = 1'b0;
`endif
    end
  end

  assign imem_addr_o  = BASE_ADDR + (32'(idx_q) << 2);
  assign imem_wdata_o = wdata_q;
  assign cpu_hold_o   = hold_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule
